rx_data_controller: RTL and testbench
=====================================

# rx_data_controller

Receive-side counterpart of the transmit data controller. Takes the per-cycle stream of ordered sets and lane data recovered from the link and rebuilds the AXI-Stream user frames: 64-bit words with `axi_valid` and `axi_last`. Handles dual-lane (one full word per DATA beat) and single-lane (two 32-bit halves per word) modes. Sits between the lane decoder and the user RX interface; there is no backpressure.

## Interface
Parameters:
- none; data width is the `AXI_DATA_SIZE` define (64); `ordered_sets_e` comes from `aurora_pkg`.

Ports:
- clk  in  1  single block clock; all inputs sampled and all outputs driven on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- single_lane  in  1  0: dual-lane, full word per DATA beat; 1: single-lane, 32-bit half per beat
- ordered_sets  in  ordered_sets_e  type of the current beat: IDLE, DATA, SEP (end of frame)
- data_in  in  AXI_DATA_SIZE  beat payload; valid only when ordered_sets == DATA
- axi_valid  out  1  one-cycle strobe per output word
- axi_last  out  1  marks the final word of a frame; only meaningful with axi_valid
- axi_data  out  AXI_DATA_SIZE  output word
- frame_err  out  1  one-cycle pulse on a malformed frame end
- frame_cnt  out  16  count of frames completed with axi_last, wraps at 0xFFFF -> 0

## Operation
- One beat per clk cycle. IDLE beats are ignored everywhere, including inside frames, so gaps are legal.
- Last-word detection uses a one-word hold register (`hold_data`, `hold_vld`):
  - When a complete word is assembled and `hold_vld` = 1, the held word is emitted with axi_last = 0. The new word then replaces it.
  - On SEP with `hold_vld` = 1, the held word is emitted with axi_last = 1. `hold_vld` clears and frame_cnt increments.
- Word assembly:
  - Dual-lane: each DATA beat is one complete word (`data_in`).
  - Single-lane: the first DATA beat stores `data_in[31:0]` as the low half (`half_vld` = 1). The second forms `{data_in[31:0], low}` and clears `half_vld`.
- State machine `mode_q`/`st`: FRAME_IDLE and IN_FRAME.
  - FRAME_IDLE -> IN_FRAME on the first DATA beat.
  - IN_FRAME -> FRAME_IDLE on SEP.
- `single_lane` is latched into `mode_q` only in FRAME_IDLE, on the same cycle as the frame's first DATA beat. Changes during IN_FRAME take effect at the next frame.
- Errors (frame_err pulses one cycle; block returns to FRAME_IDLE):
  - SEP in FRAME_IDLE (empty frame): no output, frame_cnt unchanged.
  - SEP with `half_vld` = 1 (odd half count): the held word, if any, is still emitted with axi_last = 1 and frame_cnt increments. The stray half is dropped.
- Reset (at any time, including mid-frame): discards held data and half, returns to FRAME_IDLE.
- Reset values: axi_valid = 0, axi_last = 0, axi_data = 0, frame_err = 0, frame_cnt = 0, mode_q = 0.

## Timing
- All outputs are registered.
- Word k completes at edge n. It is output during the cycle following the edge m (m > n) that samples the next DATA-completing beat or SEP.
- Minimum latency: dual-lane 1 cycle after the following beat; back-to-back DATA produces one output per cycle.
- axi_valid and axi_last de-assert the cycle after each strobe unless another emission occurs.
- axi_data holds its last value when axi_valid = 0.
- frame_cnt updates on the same edge that drives axi_last = 1.

## Structure
- aurora_pkg: `ordered_sets_e` (shared with TX) and a new `RX_FRAME_CNT_W = 16` constant.
- One sub-module: `rx_word_assembler`. It handles half/full assembly and outputs `word`, `word_vld`, and `half_pending`. The top contains the hold register, FSM, and counter.

## Test plan
- Dual-lane, reset then SEP at cycle 0, IDLE afterwards -> frame_err = 1 for exactly one cycle, no axi_valid, frame_cnt stays 0.
- Dual-lane, DATA 0xDEADB00DDEADB00D, SEP -> one axi_valid with axi_last = 1 and that data, frame_cnt = 1.
- Dual-lane, 7 DATA beats with IDLE at beats 2-4, then SEP -> 7 strobes, only the 7th with axi_last, order preserved.
- Single-lane, halves 0xDEADB00D, 0x12345678, SEP -> one word 0x12345678DEADB00D with axi_last. Toggling single_lane mid-frame has no effect.
- Single-lane, 3 halves then SEP -> one word with axi_last, frame_err pulse, frame_cnt + 1.
- rst_n low mid-frame after 3 DATA beats -> all outputs 0 immediately. A subsequent SEP gives frame_err and no stale data. Preload frame_cnt to 0xFFFF, complete a frame -> frame_cnt = 0.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared Aurora link types: ordered-set encoding and RX frame constants.
// The AXI word width comes from the AXI_DATA_SIZE define.
`ifndef AXI_DATA_SIZE
`define AXI_DATA_SIZE 64
`endif

package aurora_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    SEP  = 2'd2
  } ordered_sets_e;

  localparam int RX_FRAME_CNT_W = 16;

  typedef enum logic {
    FRAME_IDLE = 1'b0,
    IN_FRAME   = 1'b1
  } rx_state_e;

endpackage

// File: rtl/rx_word_assembler.sv
// Builds 64-bit words from full beats (dual-lane)
// or from pairs of 32-bit halves (single-lane).
`ifndef AXI_DATA_SIZE
`define AXI_DATA_SIZE 64
`endif

module rx_word_assembler (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      beat,
  input  logic                      mode,
  input  logic                      clr,
  input  logic [`AXI_DATA_SIZE-1:0] data_in,
  output logic [`AXI_DATA_SIZE-1:0] word,
  output logic                      word_vld,
  output logic                      half_pending
);

  logic        half_q;
  logic [31:0] low_q;

  assign half_pending = half_q;
  assign word_vld     = beat & (~mode | half_q);
  assign word         = mode ? {data_in[31:0], low_q} : data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q <= 1'b0;
      low_q  <= '0;
    end else if (clr) begin
      half_q <= 1'b0;
    end else if (beat && mode) begin
      half_q <= ~half_q;
      if (!half_q) low_q <= data_in[31:0];
    end
  end

endmodule

// File: rtl/rx_data_controller.sv
// RX frame rebuild: one-word hold register delays each word until
// its successor or the SEP shows whether it is the frame's last.
`ifndef AXI_DATA_SIZE
`define AXI_DATA_SIZE 64
`endif

module rx_data_controller
  import aurora_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      single_lane,
  input  ordered_sets_e             ordered_sets,
  input  logic [`AXI_DATA_SIZE-1:0] data_in,
  output logic                      axi_valid,
  output logic                      axi_last,
  output logic [`AXI_DATA_SIZE-1:0] axi_data,
  output logic                      frame_err,
  output logic [RX_FRAME_CNT_W-1:0] frame_cnt
);

  rx_state_e                 st, st_nx;
  logic                      mode_q, mode_eff;
  logic                      is_data, is_sep;
  logic [`AXI_DATA_SIZE-1:0] word, hold_data;
  logic                      word_vld, half_pending, hold_vld;
  logic                      emit, last, err, hold_ld, hold_clr;
  logic [RX_FRAME_CNT_W-1:0] cnt_q;

  assign is_data   = (ordered_sets == DATA);
  assign is_sep    = (ordered_sets == SEP);
  assign frame_cnt = cnt_q;
  // The first beat of a frame already uses the mode it latches.
  assign mode_eff  = (st == FRAME_IDLE) ? single_lane : mode_q;

  rx_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .beat         (is_data),
    .mode         (mode_eff),
    .clr          (is_sep),
    .data_in      (data_in),
    .word         (word),
    .word_vld     (word_vld),
    .half_pending (half_pending)
  );

  always_comb begin
    st_nx    = st;
    emit     = 1'b0;
    last     = 1'b0;
    err      = 1'b0;
    hold_ld  = 1'b0;
    hold_clr = 1'b0;
    unique case (1'b1)
      is_data: begin
        st_nx = IN_FRAME;
        if (word_vld) begin
          hold_ld = 1'b1;
          emit    = hold_vld;
        end
      end
      is_sep: begin
        st_nx    = FRAME_IDLE;
        hold_clr = 1'b1;
        if (st == FRAME_IDLE) begin
          err = 1'b1;
        end else begin
          emit = hold_vld;
          last = hold_vld;
          err  = half_pending;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= FRAME_IDLE;
      mode_q    <= 1'b0;
      hold_data <= '0;
      hold_vld  <= 1'b0;
      axi_valid <= 1'b0;
      axi_last  <= 1'b0;
      axi_data  <= '0;
      frame_err <= 1'b0;
      cnt_q     <= '0;
    end else begin
      st <= st_nx;
      if (st == FRAME_IDLE && is_data) mode_q <= single_lane;
      if (hold_ld) begin
        hold_data <= word;
        hold_vld  <= 1'b1;
      end else if (hold_clr) begin
        hold_vld <= 1'b0;
      end
      axi_valid <= emit;
      axi_last  <= last;
      if (emit) axi_data <= hold_data;
      frame_err <= err;
      if (last) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_data_controller.sv
// Scoreboard bench: frame-level reference model feeds an expected-output
// queue, a negedge monitor pops and compares every DUT strobe.
module tb_rx_data_controller;
  import aurora_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          single_lane = 1'b0;
  ordered_sets_e ordered_sets = IDLE;
  logic [63:0]   data_in = '0;
  logic          axi_valid, axi_last, frame_err;
  logic [63:0]   axi_data;
  logic [15:0]   frame_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        valid;
    logic        last;
    logic [63:0] data;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] fw[$];
  logic        m_in = 1'b0;
  logic        m_mode = 1'b0;
  logic        m_half = 1'b0;
  logic [31:0] m_low = '0;
  logic [15:0] m_cnt = '0;

  rx_data_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .single_lane  (single_lane),
    .ordered_sets (ordered_sets),
    .data_in      (data_in),
    .axi_valid    (axi_valid),
    .axi_last     (axi_last),
    .axi_data     (axi_data),
    .frame_err    (frame_err),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  function automatic void push_exp(logic v, logic l, logic [63:0] d,
                                   logic e, logic [15:0] c);
    exp_t x;
    x.valid = v;
    x.last  = l;
    x.data  = d;
    x.err   = e;
    x.cnt   = c;
    sb.push_back(x);
  endfunction

  always @(negedge clk) begin
    if (rst_n && (axi_valid || frame_err)) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: valid=%0b err=%0b data=%h, none expected",
                 axi_valid, frame_err, axi_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("axi_valid", 64'(axi_valid), 64'(e.valid));
        chk("frame_err", 64'(frame_err), 64'(e.err));
        chk("frame_cnt", 64'(frame_cnt), 64'(e.cnt));
        if (e.valid) begin
          chk("axi_last", 64'(axi_last), 64'(e.last));
          chk("axi_data", axi_data, e.data);
        end
      end
    end
  end

  // A word is known not to be last once the frame has a later word.
  task automatic complete(input logic [63:0] w);
    fw.push_back(w);
    if (fw.size() > 1) push_exp(1'b1, 1'b0, fw.pop_front(), 1'b0, m_cnt);
  endtask

  task automatic send(input ordered_sets_e os, input logic [63:0] d);
    ordered_sets = os;
    data_in = d;
    @(posedge clk);
    #1;
    if (os == DATA) begin
      if (!m_in) begin
        m_in = 1'b1;
        m_mode = single_lane;
      end
      if (!m_mode) complete(d);
      else if (m_half) begin
        m_half = 1'b0;
        complete({d[31:0], m_low});
      end else begin
        m_half = 1'b1;
        m_low = d[31:0];
      end
    end else if (os == SEP) begin
      if (!m_in) push_exp(1'b0, 1'b0, '0, 1'b1, m_cnt);
      else if (fw.size() != 0) begin
        m_cnt++;
        push_exp(1'b1, 1'b1, fw.pop_front(), m_half, m_cnt);
      end else if (m_half) push_exp(1'b0, 1'b0, '0, 1'b1, m_cnt);
      m_in = 1'b0;
      m_half = 1'b0;
      fw.delete();
    end
    ordered_sets = IDLE;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(axi_valid), 64'd0);
    chk({tag, "_last"}, 64'(axi_last), 64'd0);
    chk({tag, "_data"}, axi_data, 64'd0);
    chk({tag, "_err"}, 64'(frame_err), 64'd0);
    chk({tag, "_cnt"}, 64'(frame_cnt), 64'd0);
  endtask

  task automatic model_reset();
    m_in = 1'b0;
    m_mode = 1'b0;
    m_half = 1'b0;
    m_low = '0;
    m_cnt = '0;
    fw.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // empty frame right after reset
    single_lane = 1'b0;
    send(SEP, '0);
    repeat (3) send(IDLE, '0);

    // single-word dual-lane frame
    send(DATA, 64'hDEADB00DDEADB00D);
    send(SEP, '0);

    // seven words with an idle gap
    for (int i = 0; i < 10; i++) begin
      if (i >= 2 && i <= 4) send(IDLE, '0);
      else send(DATA, {$urandom, $urandom});
    end
    send(SEP, '0);

    // single-lane pair, mode toggled mid-frame
    single_lane = 1'b1;
    send(DATA, 64'h00000000DEADB00D);
    single_lane = 1'b0;
    send(DATA, 64'hFFFFFFFF12345678);
    send(SEP, '0);

    // odd half count
    single_lane = 1'b1;
    for (int i = 0; i < 3; i++) send(DATA, {$urandom, $urandom});
    send(SEP, '0);
    send(IDLE, '0);

    // reset mid-frame
    single_lane = 1'b0;
    for (int i = 0; i < 3; i++) send(DATA, {$urandom, $urandom});
    send(IDLE, '0);
    rst_n = 1'b0;
    #2;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    send(SEP, '0);
    send(IDLE, '0);

    // counter wrap
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFF;
    send(DATA, {$urandom, $urandom});
    send(DATA, {$urandom, $urandom});
    send(SEP, '0);
    send(IDLE, '0);

    // randomized frames
    for (int f = 0; f < 300; f++) begin
      int n;
      n = $urandom_range(0, 7);
      for (int i = 0; i < n; i++) begin
        single_lane = 1'($urandom);
        if ($urandom_range(0, 3) == 0) send(IDLE, '0);
        send(DATA, {$urandom, $urandom});
      end
      if ($urandom_range(0, 2) == 0) send(IDLE, '0);
      send(SEP, '0);
    end

    repeat (4) send(IDLE, '0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
